// File: rtl/alu_ser_pkg.sv
// Shared constants and FSM encoding for the ALU result serializer.
package alu_ser_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 8;
  localparam int unsigned DEF_RESULT_WIDTH = 16;
  localparam int unsigned DEF_FIFO_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } ser_state_t;

endpackage

// File: rtl/alu_result_serializer_if.sv
// ALU-result input and byte-transmit handshake bundle for the serializer.
interface alu_result_serializer_if
  import alu_ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH
) ();

  logic [RESULT_WIDTH-1:0] ALU_OUT;
  logic                    Out_Valid;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VALID;
  logic                    TX_READY;
  logic                    CLR_OVF;
  logic                    FIFO_FULL;
  logic                    OVERFLOW;

  // Serializer side.
  modport master (
    input  ALU_OUT, Out_Valid, TX_READY, CLR_OVF,
    output TX_DATA, TX_VALID, FIFO_FULL, OVERFLOW
  );

  // ALU / transmitter side.
  modport slave (
    output ALU_OUT, Out_Valid, TX_READY, CLR_OVF,
    input  TX_DATA, TX_VALID, FIFO_FULL, OVERFLOW
  );

endinterface

// File: rtl/result_fifo.sv
// Single-clock result buffer with registered full/empty flags and occupancy count.
module result_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok_c;
  logic             rd_ok_c;
  logic [CNT_W-1:0] count_nxt_c;

  // Writes into a full buffer are refused even if a read happens on the same edge.
  assign wr_ok_c     = wr_en && !full;
  assign rd_ok_c     = rd_en && !empty;
  assign count_nxt_c = count + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
  assign rd_data     = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_ok_c) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == CNT_W'(0));
    end
  end

  // Storage is left unreset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_ok_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and streams each one out as two bytes, low byte first.
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input logic                     CLK,
  input logic                     RST,
  alu_result_serializer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [RESULT_WIDTH-1:0] fifo_rd_data;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;

  ser_state_t              state_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic                    tx_valid_q;
  logic [DATA_WIDTH-1:0]   hold_hi_q;
  logic                    ovf_q;

  logic                    xfer_c;
  logic                    pop_c;
  logic                    drop_c;

  assign xfer_c = tx_valid_q && bus.TX_READY;
  assign pop_c  = !fifo_empty &&
                  ((state_q == IDLE) || ((state_q == SEND_HI) && xfer_c));
  assign drop_c = bus.Out_Valid && (fifo_count == CNT_W'(FIFO_DEPTH));

  result_fifo #(
    .WIDTH (RESULT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (bus.Out_Valid),
    .wr_data (bus.ALU_OUT),
    .rd_en   (pop_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Sticky drop flag; a drop on the clearing edge wins.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        ovf_q <= 1'b0;
    else if (drop_c) ovf_q <= 1'b1;
    else if (bus.CLR_OVF) ovf_q <= 1'b0;
  end

  // Byte sequencer; a popped word's upper byte waits in hold_hi_q.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      hold_hi_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_c) begin
            tx_data_q  <= fifo_rd_data[DATA_WIDTH-1:0];
            hold_hi_q  <= fifo_rd_data[RESULT_WIDTH-1:DATA_WIDTH];
            tx_valid_q <= 1'b1;
            state_q    <= SEND_LO;
          end else begin
            tx_valid_q <= 1'b0;
          end
        end
        SEND_LO: begin
          if (xfer_c) begin
            tx_data_q <= hold_hi_q;
            state_q   <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (xfer_c) begin
            if (pop_c) begin
              tx_data_q <= fifo_rd_data[DATA_WIDTH-1:0];
              hold_hi_q <= fifo_rd_data[RESULT_WIDTH-1:DATA_WIDTH];
              state_q   <= SEND_LO;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX_DATA   = tx_data_q;
  assign bus.TX_VALID  = tx_valid_q;
  assign bus.FIFO_FULL = fifo_full;
  assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Bench for alu_result_serializer: directed scenarios plus random traffic vs a queue model.
module tb_alu_result_serializer;
  import alu_ser_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned RW    = 16;
  localparam int unsigned DEPTH = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  alu_result_serializer_if #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW)) bus ();

  alu_result_serializer #(
    .DATA_WIDTH   (DW),
    .RESULT_WIDTH (RW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Model: queue of buffered words plus the byte currently on offer.
  logic [RW-1:0] m_buf[$];
  bit            m_valid;
  bit            m_second;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_hi;
  bit            m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_valid  = 1'b0;
    m_second = 1'b0;
    m_data   = '0;
    m_hi     = '0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_edge(input bit ov, input logic [RW-1:0] alu, input bit rdy, input bit clr);
    bit            was_full;
    bit            xfer;
    logic [RW-1:0] w;
    was_full = (m_buf.size() == DEPTH);
    xfer     = m_valid && rdy;
    if (xfer && !m_second) begin
      m_data   = m_hi;
      m_second = 1'b1;
    end else if (!m_valid || (xfer && m_second)) begin
      if (m_buf.size() > 0) begin
        w        = m_buf.pop_front();
        m_data   = w[DW-1:0];
        m_hi     = w[RW-1:DW];
        m_valid  = 1'b1;
        m_second = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (ov && was_full) m_ovf = 1'b1;
    else if (clr)       m_ovf = 1'b0;
    if (ov && !was_full) m_buf.push_back(alu);
  endtask

  task automatic compare_outputs();
    check("TX_VALID", 32'(bus.TX_VALID), 32'(m_valid));
    if (m_valid) check("TX_DATA", 32'(bus.TX_DATA), 32'(m_data));
    check("FIFO_FULL", 32'(bus.FIFO_FULL), 32'(m_buf.size() == DEPTH));
    check("OVERFLOW", 32'(bus.OVERFLOW), 32'(m_ovf));
  endtask

  task automatic cycle(input bit ov, input logic [RW-1:0] alu, input bit rdy, input bit clr);
    bus.Out_Valid = ov;
    bus.ALU_OUT   = alu;
    bus.TX_READY  = rdy;
    bus.CLR_OVF   = clr;
    @(posedge CLK);
    model_edge(ov, alu, rdy, clr);
    #1;
    compare_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.TX_VALID), 32'd0);
    check({tag, "_data"},  32'(bus.TX_DATA),  32'd0);
    check({tag, "_full"},  32'(bus.FIFO_FULL), 32'd0);
    check({tag, "_ovf"},   32'(bus.OVERFLOW), 32'd0);
  endtask

  int ov_pct[4]  = '{50, 90, 20, 100};
  int rdy_pct[4] = '{90, 30, 50, 100};

  initial begin
    bus.Out_Valid = 1'b0;
    bus.ALU_OUT   = '0;
    bus.TX_READY  = 1'b0;
    bus.CLR_OVF   = 1'b0;
    model_reset();
    #2;
    check_all_zero("reset");
    #10 RST = 1'b1;

    // Single result: first byte two cycles after the write.
    cycle(1'b1, 16'hA55A, 1'b1, 1'b0);
    check("lat_c1_valid", 32'(bus.TX_VALID), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("a55a_lo", 32'(bus.TX_DATA), 32'h5A);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("a55a_hi", 32'(bus.TX_DATA), 32'hA5);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("a55a_done", 32'(bus.TX_VALID), 32'd0);

    // Back-pressure holds the low byte.
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b0, 1'b0);
    check("bp_hold", 32'(bus.TX_DATA), 32'h34);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Burst of four with no valid gap.
    for (int i = 1; i <= 4; i++) cycle(1'b1, RW'(i), 1'b1, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);

    // Overflow: six results with the transmitter stalled.
    for (int i = 0; i < 6; i++) cycle(1'b1, RW'(16'h0010 + i), 1'b0, 1'b0);
    check("ovf_full", 32'(bus.FIFO_FULL), 32'd1);
    check("ovf_set", 32'(bus.OVERFLOW), 32'd1);
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("ovf_clr", 32'(bus.OVERFLOW), 32'd0);

    // Full buffer, SEND_HI pop and a write on the same edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, RW'(16'h0100 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("pop_drop_ovf", 32'(bus.OVERFLOW), 32'd1);
    check("pop_drop_notfull", 32'(bus.FIFO_FULL), 32'd0);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);

    // Reset mid-frame in SEND_HI with three words buffered.
    for (int i = 0; i < 4; i++) cycle(1'b1, RW'(16'h0200 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    RST = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (2) @(posedge CLK);
    #3 RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check("post_rst_idle", 32'(bus.TX_VALID), 32'd0);
    end

    // Random traffic in phases of differing load and back-pressure.
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 600; i++) begin
        cycle(($urandom_range(99) < 32'(ov_pct[p])), RW'($urandom),
              ($urandom_range(99) < 32'(rdy_pct[p])), ($urandom_range(99) < 3));
      end
    end
    repeat (20) cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(bus.TX_VALID), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
